// File: rtl/btc_pkg.sv
// Shared constants, feeder state encoding and byte-order helpers for the
// double-SHA-256 nonce feeder.
package btc_pkg;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] PAD_START  = 32'h8000_0000;
  localparam logic [31:0] PAD_LEN_P1 = 32'h0000_0280;
  localparam logic [31:0] PAD_LEN_P2 = 32'h0000_0100;

  typedef enum logic [2:0] {
    IDLE,
    P1_START,
    P1_WAIT,
    P2_START,
    P2_WAIT,
    CHECK,
    FINISH
  } feeder_state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Digest bytes come out big-endian per word; the target is compared little-endian.
  function automatic logic [255:0] byte_rev256(input logic [255:0] x);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = x[255-8*i -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/btc_nonce_feeder_if.sv
// Word-streaming link between the nonce feeder (master) and the
// sha256_stream hashing core (slave).
interface btc_nonce_feeder_if;

  logic         core_start;
  logic [255:0] core_state_in;
  logic [255:0] core_state_out;
  logic         core_done;
  logic [3:0]   core_addr;
  logic         core_rq;
  logic         core_rdy;
  logic [31:0]  core_data;

  modport master (
    output core_start, core_state_in, core_rdy, core_data,
    input  core_state_out, core_done, core_addr, core_rq
  );

  modport slave (
    input  core_start, core_state_in, core_rdy, core_data,
    output core_state_out, core_done, core_addr, core_rq
  );

endinterface

// File: rtl/btc_word_server.sv
// Serves padded message words to the hashing core: pass 1 is the header
// tail plus nonce, pass 2 is the first digest; one word per two cycles.
module btc_word_server
  import btc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pass2_i,
  input  logic [95:0]  tail_i,
  input  logic [31:0]  nonce_i,
  input  logic [255:0] digest1_i,
  input  logic [3:0]   addr_i,
  input  logic         rq_i,
  output logic         rdy_o,
  output logic [31:0]  data_o
);

  logic        rdy_q;
  logic [31:0] data_q;
  logic [31:0] word_d;

  always_comb begin
    word_d = 32'h0;
    if (pass2_i) begin
      if (!addr_i[3]) begin
        word_d = digest1_i[{~addr_i[2:0], 5'd0} +: 32];
      end else if (addr_i == 4'd8) begin
        word_d = PAD_START;
      end else if (addr_i == 4'd15) begin
        word_d = PAD_LEN_P2;
      end
    end else begin
      case (addr_i)
        4'd0:    word_d = tail_i[95:64];
        4'd1:    word_d = tail_i[63:32];
        4'd2:    word_d = tail_i[31:0];
        4'd3:    word_d = bswap32(nonce_i);
        4'd4:    word_d = PAD_START;
        4'd15:   word_d = PAD_LEN_P1;
        default: word_d = 32'h0;
      endcase
    end
  end

  // rdy drops for one cycle after every word so the core sees each strobe exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q  <= 1'b0;
      data_q <= 32'h0;
    end else if (rq_i && !rdy_q) begin
      rdy_q  <= 1'b1;
      data_q <= word_d;
    end else begin
      rdy_q  <= 1'b0;
    end
  end

  assign rdy_o  = rdy_q;
  assign data_o = data_q;

endmodule

// File: rtl/btc_nonce_feeder.sv
// Double-SHA-256 nonce search sequencer driving an external sha256_stream core.
// Define BTC_FEEDER_STATS_EN to add the hash_count_o / last_nonce_o statistics outputs.
module btc_nonce_feeder
  import btc_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go_i,
  input  logic         abort_i,
  input  logic [255:0] midstate_i,
  input  logic [95:0]  tail_i,
  input  logic [31:0]  nonce_start_i,
  input  logic [31:0]  nonce_end_i,
  input  logic [255:0] target_i,
  output logic         busy_o,
  output logic         found_o,
  output logic         exhausted_o,
  output logic [31:0]  found_nonce_o,
  output logic [255:0] hash_out_o,
`ifdef BTC_FEEDER_STATS_EN
  output logic [31:0]  hash_count_o,
  output logic [31:0]  last_nonce_o,
`endif
  btc_nonce_feeder_if.master core_if
);

  feeder_state_e state_q;
  logic [255:0]  midstate_q;
  logic [95:0]   tail_q;
  logic [31:0]   nonce_end_q;
  logic [255:0]  target_q;
  logic [31:0]   nonce_q;
  logic [255:0]  digest1_q;
  logic [255:0]  digest2_q;
  logic          abort_pend_q;
  logic          busy_q;
  logic          found_q;
  logic          exhausted_q;
  logic [31:0]   found_nonce_q;
  logic [255:0]  hash_out_q;
  logic          core_start_q;
`ifdef BTC_FEEDER_STATS_EN
  logic [31:0]   hash_count_q;
  logic [31:0]   last_nonce_q;
`endif

  logic          pass2;
  logic [255:0]  hval;
  logic          hit;
  logic          stop_now;

  assign pass2    = (state_q == P2_START) || (state_q == P2_WAIT);
  assign hval     = byte_rev256(digest2_q);
  assign hit      = (hval <= target_q);
  assign stop_now = (nonce_q == nonce_end_q) || abort_pend_q || abort_i;

  // The core cannot be interrupted, so abort only takes effect at the CHECK of the current nonce.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      midstate_q    <= '0;
      tail_q        <= '0;
      nonce_end_q   <= '0;
      target_q      <= '0;
      nonce_q       <= '0;
      digest1_q     <= '0;
      digest2_q     <= '0;
      abort_pend_q  <= 1'b0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      found_nonce_q <= '0;
      hash_out_q    <= '0;
      core_start_q  <= 1'b0;
`ifdef BTC_FEEDER_STATS_EN
      hash_count_q  <= '0;
      last_nonce_q  <= '0;
`endif
    end else begin
      core_start_q <= 1'b0;
      if (state_q != IDLE && abort_i) begin
        abort_pend_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (go_i) begin
            midstate_q   <= midstate_i;
            tail_q       <= tail_i;
            nonce_end_q  <= nonce_end_i;
            target_q     <= target_i;
            nonce_q      <= nonce_start_i;
            found_q      <= 1'b0;
            exhausted_q  <= 1'b0;
            busy_q       <= 1'b1;
            abort_pend_q <= 1'b0;
            core_start_q <= 1'b1;
            state_q      <= P1_START;
`ifdef BTC_FEEDER_STATS_EN
            hash_count_q <= '0;
`endif
          end
        end
        P1_START: state_q <= P1_WAIT;
        P1_WAIT: begin
          if (core_if.core_done) begin
            digest1_q    <= core_if.core_state_out;
            core_start_q <= 1'b1;
            state_q      <= P2_START;
          end
        end
        P2_START: state_q <= P2_WAIT;
        P2_WAIT: begin
          if (core_if.core_done) begin
            digest2_q <= core_if.core_state_out;
            state_q   <= CHECK;
          end
        end
        CHECK: begin
`ifdef BTC_FEEDER_STATS_EN
          if (hash_count_q != 32'hFFFF_FFFF) begin
            hash_count_q <= hash_count_q + 32'd1;
          end
          last_nonce_q <= nonce_q;
`endif
          if (hit) begin
            found_q       <= 1'b1;
            found_nonce_q <= nonce_q;
            hash_out_q    <= digest2_q;
            abort_pend_q  <= 1'b0;
            state_q       <= FINISH;
          end else if (stop_now) begin
            exhausted_q  <= 1'b1;
            abort_pend_q <= 1'b0;
            state_q      <= FINISH;
          end else begin
            nonce_q      <= nonce_q + 32'd1;
            core_start_q <= 1'b1;
            state_q      <= P1_START;
          end
        end
        FINISH: begin
          busy_q       <= 1'b0;
          abort_pend_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  btc_word_server u_word_server (
    .clk       (clk),
    .rst_n     (rst_n),
    .pass2_i   (pass2),
    .tail_i    (tail_q),
    .nonce_i   (nonce_q),
    .digest1_i (digest1_q),
    .addr_i    (core_if.core_addr),
    .rq_i      (core_if.core_rq),
    .rdy_o     (core_if.core_rdy),
    .data_o    (core_if.core_data)
  );

  assign core_if.core_start    = core_start_q;
  assign core_if.core_state_in = pass2 ? SHA256_IV : midstate_q;

  assign busy_o        = busy_q;
  assign found_o       = found_q;
  assign exhausted_o   = exhausted_q;
  assign found_nonce_o = found_nonce_q;
  assign hash_out_o    = hash_out_q;
`ifdef BTC_FEEDER_STATS_EN
  assign hash_count_o  = hash_count_q;
  assign last_nonce_o  = last_nonce_q;
`endif

endmodule
